// File: rtl/common_pkg.sv
// Common machine-wide widths and muldiv latency defaults.
package common_pkg;

   localparam int unsigned XLEN              = 64;
   localparam int unsigned WLEN              = 32;
   localparam int unsigned ILEN              = 32;
   localparam int unsigned REG_W             = 5;
   localparam int unsigned MUL_LAT_DEFAULT   = 3;
   localparam int unsigned DIV_ITERS_DEFAULT = 64;

endpackage

// File: rtl/pipes_pkg.sv
// Pipeline payload types, alu function codes and muldiv op classification helpers.
package pipes_pkg;

   import common_pkg::*;

   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
      ALU_ADDW, ALU_SUBW,
      ALU_MUL, ALU_MULW,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
      ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW
   } alufunc_t;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} muldiv_state_t;

   typedef struct packed {
      alufunc_t alufunc;
      logic     regwrite;
      logic     memread;
      logic     memwrite;
   } control_t;

   typedef struct packed {
      logic             valid;
      logic [XLEN-1:0]  pc;
      logic [ILEN-1:0]  raw_instr;
      control_t         ctl;
      logic [REG_W-1:0] dst;
      logic [XLEN-1:0]  srca;
      logic [XLEN-1:0]  srcb;
      logic [XLEN-1:0]  MemWriteData;
   } decoded_data_t;

   typedef struct packed {
      logic             valid;
      logic [XLEN-1:0]  pc;
      logic [ILEN-1:0]  raw_instr;
      control_t         ctl;
      logic [REG_W-1:0] dst;
      logic [XLEN-1:0]  alu_out;
      logic [XLEN-1:0]  MemWriteData;
   } execute_data_t;

   function automatic logic is_md(input alufunc_t f);
      return f inside {ALU_MUL, ALU_MULW, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
                       ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW};
   endfunction

   function automatic logic md_is_div(input alufunc_t f);
      return f inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
                       ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW};
   endfunction

   function automatic logic md_is_signed(input alufunc_t f);
      return f inside {ALU_DIV, ALU_REM, ALU_DIVW, ALU_REMW};
   endfunction

   function automatic logic md_is_rem(input alufunc_t f);
      return f inside {ALU_REM, ALU_REMU, ALU_REMW, ALU_REMUW};
   endfunction

   function automatic logic md_is_w(input alufunc_t f);
      return f inside {ALU_MULW, ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW};
   endfunction

   function automatic logic [XLEN-1:0] sext_w(input logic [WLEN-1:0] x);
      return {{(XLEN-WLEN){x[WLEN-1]}}, x};
   endfunction

   function automatic logic [XLEN-1:0] zext_w(input logic [WLEN-1:0] x);
      return {{(XLEN-WLEN){1'b0}}, x};
   endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle combinational integer alu for non-muldiv functions.
module alu
   import common_pkg::*;
   import pipes_pkg::*;
(
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  alufunc_t        func,
   output logic [XLEN-1:0] y
);

   localparam int unsigned SHAMT_W = $clog2(XLEN);

   // function decode; muldiv codes produce zero here
   always_comb begin
      y = '0;
      case (func)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_XOR:  y = a ^ b;
         ALU_SLL:  y = a << b[SHAMT_W-1:0];
         ALU_SRL:  y = a >> b[SHAMT_W-1:0];
         ALU_SRA:  y = XLEN'($signed(a) >>> b[SHAMT_W-1:0]);
         ALU_SLT:  y = XLEN'($signed(a) < $signed(b));
         ALU_SLTU: y = XLEN'(a < b);
         ALU_ADDW: y = sext_w(WLEN'(a + b));
         ALU_SUBW: y = sext_w(WLEN'(a - b));
         default:  y = '0;
      endcase
   end

endmodule

// File: rtl/muldiv.sv
// Multi-cycle M-extension unit: pipelined multiplier and restoring divider.
// Build option: MULDIV_EARLY_OUT_EN sends trivial divisions straight to DONE.
module muldiv
   import common_pkg::*;
   import pipes_pkg::*;
#(
   parameter int unsigned MUL_LAT   = MUL_LAT_DEFAULT,
   parameter int unsigned DIV_ITERS = DIV_ITERS_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  alufunc_t        op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   input  logic            hold,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CNT_MAX = (DIV_ITERS > MUL_LAT) ? DIV_ITERS : MUL_LAT;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   muldiv_state_t    state_q, state_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   alufunc_t         op_q, op_n;
   logic [XLEN-1:0]  quo_q, quo_n, rem_q, rem_n, dvs_q, dvs_n, dvd_q, dvd_n;
   logic [XLEN-1:0]  prod_q, prod_n, result_q, result_n;
   logic             nq_q, nq_n, nr_q, nr_n, dz_q, dz_n;

   logic [XLEN-1:0]  a_ext, b_ext, a_mag, b_mag;
   logic             sgn, sa, sb, dz;
   logic [XLEN:0]    rem_sh, diff;
   logic [XLEN-1:0]  step_quo, step_rem;

   // Apply signs and special cases to the magnitude quotient/remainder
   function automatic logic [XLEN-1:0] div_final(
      input alufunc_t f, input logic [XLEN-1:0] q_mag, input logic [XLEN-1:0] r_mag,
      input logic nq, input logic nr, input logic dzero, input logic [XLEN-1:0] dvd);
      logic [XLEN-1:0] q, r, sel;
      q = nq ? -q_mag : q_mag;
      r = nr ? -r_mag : r_mag;
      if (dzero) begin
         q = '1;
         r = dvd;
      end
      sel = md_is_rem(f) ? r : q;
      return md_is_w(f) ? sext_w(sel[WLEN-1:0]) : sel;
   endfunction

   // operand extension and magnitudes for the incoming op
   always_comb begin
      sgn   = md_is_signed(op);
      a_ext = a;
      b_ext = b;
      if (md_is_w(op)) begin
         a_ext = sgn ? sext_w(a[WLEN-1:0]) : zext_w(a[WLEN-1:0]);
         b_ext = sgn ? sext_w(b[WLEN-1:0]) : zext_w(b[WLEN-1:0]);
      end
      sa    = sgn & a_ext[XLEN-1];
      sb    = sgn & b_ext[XLEN-1];
      a_mag = sa ? -a_ext : a_ext;
      b_mag = sb ? -b_ext : b_ext;
      dz    = (b_ext == '0);
   end

   // one restoring-division shift/subtract step
   always_comb begin
      rem_sh   = {rem_q, quo_q[XLEN-1]};
      diff     = rem_sh - {1'b0, dvs_q};
      step_rem = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
      step_quo = {quo_q[XLEN-2:0], ~diff[XLEN]};
   end

`ifdef MULDIV_EARLY_OUT_EN
   localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] MIN_W = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};

   logic            ovf, early;
   logic [XLEN-1:0] early_res;

   // detect divisions whose result is known without iterating
   always_comb begin
      ovf       = sgn & (a_ext == (md_is_w(op) ? MIN_W : MIN_D)) & (b_ext == '1);
      early     = md_is_div(op) & (dz | ovf | (a_mag < b_mag));
      early_res = div_final(op, ovf ? a_mag : '0, ovf ? '0 : a_mag, sa ^ sb, sa, dz, a_ext);
   end
`endif

   // next-state and datapath update
   always_comb begin
      state_n  = state_q;
      cnt_n    = cnt_q;
      op_n     = op_q;
      quo_n    = quo_q;
      rem_n    = rem_q;
      dvs_n    = dvs_q;
      dvd_n    = dvd_q;
      prod_n   = prod_q;
      nq_n     = nq_q;
      nr_n     = nr_q;
      dz_n     = dz_q;
      result_n = result_q;
      if (flush) begin
         state_n = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  op_n   = op;
                  quo_n  = a_mag;
                  rem_n  = '0;
                  dvs_n  = b_mag;
                  dvd_n  = a_ext;
                  nq_n   = sa ^ sb;
                  nr_n   = sa;
                  dz_n   = dz;
                  prod_n = a * b;
`ifdef MULDIV_EARLY_OUT_EN
                  if (early) begin
                     state_n  = DONE;
                     result_n = early_res;
                  end else
`endif
                  begin
                     state_n = BUSY;
                     cnt_n   = md_is_div(op) ? CNT_W'(DIV_ITERS) : CNT_W'(MUL_LAT);
                  end
               end
            end
            BUSY: begin
               cnt_n = cnt_q - CNT_W'(1);
               if (md_is_div(op_q)) begin
                  quo_n = step_quo;
                  rem_n = step_rem;
               end
               if (cnt_q == CNT_W'(1)) begin
                  state_n  = DONE;
                  result_n = md_is_div(op_q)
                           ? div_final(op_q, step_quo, step_rem, nq_q, nr_q, dz_q, dvd_q)
                           : (md_is_w(op_q) ? sext_w(prod_q[WLEN-1:0]) : prod_q);
               end
            end
            DONE: begin
               if (!hold) state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= ALU_ADD;
         quo_q    <= '0;
         rem_q    <= '0;
         dvs_q    <= '0;
         dvd_q    <= '0;
         prod_q   <= '0;
         nq_q     <= 1'b0;
         nr_q     <= 1'b0;
         dz_q     <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_n;
         cnt_q    <= cnt_n;
         op_q     <= op_n;
         quo_q    <= quo_n;
         rem_q    <= rem_n;
         dvs_q    <= dvs_n;
         dvd_q    <= dvd_n;
         prod_q   <= prod_n;
         nq_q     <= nq_n;
         nr_q     <= nr_n;
         dz_q     <= dz_n;
         result_q <= result_n;
      end
   end

   assign done   = (state_q == DONE);
   assign result = result_q;

endmodule

// File: rtl/execute.sv
// Execute stage: combinational alu plus stalling muldiv unit.
// Build option: MULDIV_EARLY_OUT_EN (passed through to muldiv).
module execute
   import common_pkg::*;
   import pipes_pkg::*;
#(
   parameter int unsigned MUL_LAT   = MUL_LAT_DEFAULT,
   parameter int unsigned DIV_ITERS = DIV_ITERS_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  decoded_data_t dataD,
   input  logic          stallM,
   input  logic          flushE,
   output execute_data_t dataE_nxt,
   output logic          stallE
);

   logic            md_op, md_start, md_done;
   logic [XLEN-1:0] alu_result, md_result;

   assign md_op    = is_md(dataD.ctl.alufunc);
   assign md_start = ~reset & dataD.valid & md_op & ~flushE;
   assign stallE   = ~reset & dataD.valid & md_op & ~md_done & ~flushE;

   alu u_alu (
      .a    (dataD.srca),
      .b    (dataD.srcb),
      .func (dataD.ctl.alufunc),
      .y    (alu_result)
   );

   muldiv #(
      .MUL_LAT   (MUL_LAT),
      .DIV_ITERS (DIV_ITERS)
   ) u_muldiv (
      .clk    (clk),
      .reset  (reset),
      .start  (md_start),
      .op     (dataD.ctl.alufunc),
      .a      (dataD.srca),
      .b      (dataD.srcb),
      .flush  (flushE),
      .hold   (stallM),
      .done   (md_done),
      .result (md_result)
   );

   // assemble the next E/M bundle
   always_comb begin
      dataE_nxt              = '0;
      dataE_nxt.valid        = ~reset & dataD.valid & ~stallE & ~flushE;
      dataE_nxt.pc           = dataD.pc;
      dataE_nxt.raw_instr    = dataD.raw_instr;
      dataE_nxt.ctl          = dataD.ctl;
      dataE_nxt.dst          = dataD.dst;
      dataE_nxt.alu_out      = md_op ? md_result : alu_result;
      dataE_nxt.MemWriteData = dataD.MemWriteData;
   end

endmodule

// File: tb/tb_execute.sv
// Directed self-checking bench for the execute stage.
module tb_execute;

   import common_pkg::*;
   import pipes_pkg::*;

   localparam int DIV_STALL = 65;
   localparam int MUL_STALL = 4;
`ifdef MULDIV_EARLY_OUT_EN
   localparam int EDGE_STALL = 1;
`else
   localparam int EDGE_STALL = 65;
`endif

   logic          clk;
   logic          reset;
   logic          stallM;
   logic          flushE;
   logic          stallE;
   decoded_data_t dataD;
   execute_data_t dataE_nxt;

   int checks = 0;
   int errors = 0;
   int stalls;

   execute #(.MUL_LAT(3), .DIV_ITERS(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .dataD     (dataD),
      .stallM    (stallM),
      .flushE    (flushE),
      .dataE_nxt (dataE_nxt),
      .stallE    (stallE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
      end
   endtask

   task automatic drive(input alufunc_t f, input logic [63:0] a, input logic [63:0] b);
      dataD.valid       = 1'b1;
      dataD.ctl.alufunc = f;
      dataD.srca        = a;
      dataD.srcb        = b;
      #1;
   endtask

   // present an op after the next edge and count stall cycles (bounded)
   task automatic run_md(input alufunc_t f, input logic [63:0] a, input logic [63:0] b,
                         output int n);
      tick();
      drive(f, a, b);
      n = 0;
      while (stallE === 1'b1 && n < 300) begin
         n++;
         tick();
      end
   endtask

   initial begin
      reset              = 1'b1;
      stallM             = 1'b0;
      flushE             = 1'b0;
      dataD              = '0;
      dataD.pc           = 64'h0000_0000_0000_1000;
      dataD.raw_instr    = 32'h02c5_c533;
      dataD.dst          = 5'd10;
      dataD.MemWriteData = 64'h0000_0000_dead_beef;
      dataD.ctl.regwrite = 1'b1;
      dataD.valid        = 1'b1;
      dataD.ctl.alufunc  = ALU_DIV;
      dataD.srca         = 64'd100;
      dataD.srcb         = 64'd7;
      tick();
      tick();
      check("reset_stallE", 64'(stallE), 64'd0);
      check("reset_valid", 64'(dataE_nxt.valid), 64'd0);
      reset       = 1'b0;
      dataD.valid = 1'b0;

      run_md(ALU_DIV, 64'd100, 64'd7, stalls);
      check("div_stalls", 64'(stalls), 64'(DIV_STALL));
      check("div_q", dataE_nxt.alu_out, 64'd14);
      check("div_valid", 64'(dataE_nxt.valid), 64'd1);
      check("pass_pc", dataE_nxt.pc, 64'h0000_0000_0000_1000);
      check("pass_dst", 64'(dataE_nxt.dst), 64'd10);
      check("pass_instr", 64'(dataE_nxt.raw_instr), 64'h0000_0000_02c5_c533);
      check("pass_wdata", dataE_nxt.MemWriteData, 64'h0000_0000_dead_beef);

      run_md(ALU_REM, 64'd100, 64'd7, stalls);
      check("rem_stalls", 64'(stalls), 64'(DIV_STALL));
      check("rem_r", dataE_nxt.alu_out, 64'd2);

      run_md(ALU_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, stalls);
      check("rem_neg", dataE_nxt.alu_out, 64'hFFFF_FFFF_FFFF_FFFF);

      run_md(ALU_DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, stalls);
      check("div_neg", dataE_nxt.alu_out, 64'hFFFF_FFFF_FFFF_FFF2);

      run_md(ALU_DIVU, 64'd5, 64'd0, stalls);
      check("divu0_stalls", 64'(stalls), 64'(EDGE_STALL));
      check("divu0", dataE_nxt.alu_out, 64'hFFFF_FFFF_FFFF_FFFF);

      run_md(ALU_REMU, 64'd5, 64'd0, stalls);
      check("remu0_stalls", 64'(stalls), 64'(EDGE_STALL));
      check("remu0", dataE_nxt.alu_out, 64'd5);

      run_md(ALU_DIVW, 64'd5, 64'd0, stalls);
      check("divw0", dataE_nxt.alu_out, 64'hFFFF_FFFF_FFFF_FFFF);

      run_md(ALU_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, stalls);
      check("ovf_div_stalls", 64'(stalls), 64'(EDGE_STALL));
      check("ovf_div", dataE_nxt.alu_out, 64'h8000_0000_0000_0000);

      run_md(ALU_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, stalls);
      check("ovf_rem_stalls", 64'(stalls), 64'(EDGE_STALL));
      check("ovf_rem", dataE_nxt.alu_out, 64'd0);

      run_md(ALU_MULW, 64'h0000_0000_7FFF_FFFF, 64'd2, stalls);
      check("mulw_stalls", 64'(stalls), 64'(MUL_STALL));
      check("mulw", dataE_nxt.alu_out, 64'hFFFF_FFFF_FFFF_FFFE);

      run_md(ALU_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC, stalls);
      check("mul_stalls", 64'(stalls), 64'(MUL_STALL));
      check("mul", dataE_nxt.alu_out, 64'hFFFF_FFFF_FFFF_FFF4);

      // memory stall while in DONE: output held, no restart
      stallM = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_stallE", 64'(stallE), 64'd0);
         check("hold_valid", 64'(dataE_nxt.valid), 64'd1);
         check("hold_out", dataE_nxt.alu_out, 64'hFFFF_FFFF_FFFF_FFF4);
      end
      stallM = 1'b0;
      tick();
      dataD.valid = 1'b0;
      #1;

      // flush a division at cycle 10 of BUSY
      tick();
      drive(ALU_DIV, 64'd100, 64'd7);
      check("flush_start_stall", 64'(stallE), 64'd1);
      repeat (10) tick();
      check("flush_busy_stall", 64'(stallE), 64'd1);
      flushE = 1'b1;
      #1;
      check("flush_stallE", 64'(stallE), 64'd0);
      check("flush_valid", 64'(dataE_nxt.valid), 64'd0);
      tick();
      flushE = 1'b0;
      drive(ALU_ADD, 64'd1, 64'd2);
      check("add_out", dataE_nxt.alu_out, 64'd3);
      check("add_valid", 64'(dataE_nxt.valid), 64'd1);
      check("add_stallE", 64'(stallE), 64'd0);
      run_md(ALU_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC, stalls);
      check("post_flush_stalls", 64'(stalls), 64'(MUL_STALL));
      check("post_flush_mul", dataE_nxt.alu_out, 64'hFFFF_FFFF_FFFF_FFF4);

      // reset in the middle of BUSY
      tick();
      drive(ALU_DIV, 64'd100, 64'd7);
      repeat (5) tick();
      check("rst_busy_stall", 64'(stallE), 64'd1);
      reset = 1'b1;
      tick();
      check("rst_stallE", 64'(stallE), 64'd0);
      check("rst_valid", 64'(dataE_nxt.valid), 64'd0);
      reset       = 1'b0;
      dataD.valid = 1'b0;
      run_md(ALU_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC, stalls);
      check("post_rst_stalls", 64'(stalls), 64'(MUL_STALL));
      check("post_rst_mul", dataE_nxt.alu_out, 64'hFFFF_FFFF_FFFF_FFF4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
